// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Owns the single write port of the register file. Several writeback
//   producers (ALU, load unit, CSR unit, ...) compete for the port and a
//   round-robin arbiter grants at most one of them per cycle. The winning
//   write is registered and presented to the register file one cycle later.
//   A pending-write scoreboard (one busy bit per architectural register) is
//   set when the issue stage reserves a destination and cleared when the
//   corresponding registered write goes out, so the issue stage can stall
//   on read-after-write hazards.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/rd/data per-requester writeback request (packed, requester i
//                     at [i*AW +: AW] / [i*XLEN +: XLEN])
//   req_ready         one-hot grant, the request is consumed this cycle
//   rf_write/rd/writedata
//                     registered register-file write port
//   reserve_valid/rd  issue stage reserving a destination register
//   flush             synchronous clear of every busy bit
//   rs1, rs2          issue-stage source indices
//   hazard_rs1/rs2    source has a pending write
//   busy_mask         scoreboard contents, bit 0 always 0
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*AW-1:0]     req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rf_write,
    output logic [AW-1:0]          rf_rd,
    output logic [XLEN-1:0]        rf_writedata,
    input  logic                   reserve_valid,
    input  logic [AW-1:0]          reserve_rd,
    input  logic                   flush,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic                   hazard_rs1,
    output logic                   hazard_rs2,
    output logic [(2**AW)-1:0]     busy_mask
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2**AW;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_write_q, rf_write_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_writedata_q, rf_writedata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] grant;
    logic            found;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            transfer;
    int              idx;

    // Round-robin search starting at ptr_q, wrapping at NREQ-1 back to 0.
    // The index is wrapped by subtraction so NREQ need not be a power of two.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        win_idx  = '0;
        win_rd   = '0;
        win_data = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
                win_rd     = req_rd[idx*AW +: AW];
                win_data   = req_data[idx*XLEN +: XLEN];
            end
        end
    end

    // Next-state for pointer, registered write port and scoreboard.
    // A granted request with rd=0 is consumed but never produces a write.
    // Clear is applied before set so a same-edge reservation of the register
    // being written survives: it belongs to a newer, still outstanding write.
    always_comb begin
        transfer = found;

        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end

        rf_write_d     = transfer && (win_rd != '0);
        rf_rd_d        = transfer ? win_rd   : rf_rd_q;
        rf_writedata_d = transfer ? win_data : rf_writedata_q;

        busy_d = busy_q;
        if (rf_write_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (reserve_valid && (reserve_rd != '0)) begin
            busy_d[reserve_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q          <= '0;
            rf_write_q     <= 1'b0;
            rf_rd_q        <= '0;
            rf_writedata_q <= '0;
            busy_q         <= '0;
        end else begin
            ptr_q          <= ptr_d;
            rf_write_q     <= rf_write_d;
            rf_rd_q        <= rf_rd_d;
            rf_writedata_q <= rf_writedata_d;
            busy_q         <= busy_d;
        end
    end

    // The register file read is not write-through, so a source matching the
    // write going out this cycle is still a hazard even though its busy bit
    // is about to clear.
    always_comb begin
        req_ready    = reset ? '0 : grant;
        rf_write     = rf_write_q;
        rf_rd        = rf_rd_q;
        rf_writedata = rf_writedata_q;
        busy_mask    = busy_q;
        hazard_rs1   = !reset && (busy_q[rs1] ||
                       (rf_write_q && (rf_rd_q == rs1) && (rs1 != '0)));
        hazard_rs2   = !reset && (busy_q[rs2] ||
                       (rf_write_q && (rf_rd_q == rs2) && (rs2 != '0)));
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Purpose:
//   Self-checking bench for rf_wb_arbiter (NREQ=3, XLEN=32, AW=5). A small
//   behavioural model (pointer integer, busy bit array, one pending write)
//   predicts grants, the registered write port, the scoreboard and the hazard
//   outputs every cycle. Directed sequences are followed by randomized
//   traffic that obeys the hold-until-granted handshake.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_write;
    logic [AW-1:0]        rf_rd;
    logic [XLEN-1:0]      rf_writedata;
    logic                 reserve_valid;
    logic [AW-1:0]        reserve_rd;
    logic                 flush;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 hazard_rs1;
    logic                 hazard_rs2;
    logic [31:0]          busy_mask;

    int compared;
    int mismatched;

    // Reference model state
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_wr_valid;
    logic [4:0]  m_wr_rd;
    logic [31:0] m_wr_data;

    // Randomized requester state (hold until granted)
    logic        pend_v    [NREQ];
    logic [4:0]  pend_rd   [NREQ];
    logic [31:0] pend_data [NREQ];

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_write      (rf_write),
        .rf_rd         (rf_rd),
        .rf_writedata  (rf_writedata),
        .reserve_valid (reserve_valid),
        .reserve_rd    (reserve_rd),
        .flush         (flush),
        .rs1           (rs1),
        .rs2           (rs2),
        .hazard_rs1    (hazard_rs1),
        .hazard_rs2    (hazard_rs2),
        .busy_mask     (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_ptr      = 0;
        m_busy     = '0;
        m_wr_valid = 1'b0;
        m_wr_rd    = '0;
        m_wr_data  = '0;
    endtask

    function automatic logic modelHazard(input logic [4:0] rs);
        return m_busy[rs] || (m_wr_valid && (m_wr_rd == rs) && (rs != 5'd0));
    endfunction

    // Drives one cycle of inputs (called just after a falling edge), checks
    // every output against the model mid-cycle, then advances the model
    // across the rising edge. Returns the index granted, or -1.
    task automatic applyStimulus(input logic [2:0] v, input logic [14:0] rd,
                                 input logic [95:0] data, input logic rv,
                                 input logic [4:0] rrd, input logic fl,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 output int granted);
        logic [2:0] exp_grant;
        int         w;
        logic [4:0] w_rd;
        req_valid     = v;
        req_rd        = rd;
        req_data      = data;
        reserve_valid = rv;
        reserve_rd    = rrd;
        flush         = fl;
        rs1           = r1;
        rs2           = r2;
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        exp_grant = '0;
        if (w >= 0) exp_grant[w] = 1'b1;
        checkOutput("req_ready", 64'(req_ready), 64'(exp_grant));
        checkOutput("rf_write", 64'(rf_write), 64'(m_wr_valid));
        if (m_wr_valid) begin
            checkOutput("rf_rd", 64'(rf_rd), 64'(m_wr_rd));
            checkOutput("rf_writedata", 64'(rf_writedata), 64'(m_wr_data));
        end
        checkOutput("busy_mask", 64'(busy_mask), 64'(m_busy));
        checkOutput("hazard_rs1", 64'(hazard_rs1), 64'(modelHazard(r1)));
        checkOutput("hazard_rs2", 64'(hazard_rs2), 64'(modelHazard(r2)));
        @(posedge clk);
        // Scoreboard: the outgoing write clears, then flush or a reservation.
        if (m_wr_valid) m_busy[m_wr_rd] = 1'b0;
        if (fl) m_busy = '0;
        else if (rv && rrd != 5'd0) m_busy[rrd] = 1'b1;
        if (w >= 0) begin
            w_rd       = rd[w*5 +: 5];
            m_wr_valid = (w_rd != 5'd0);
            m_wr_rd    = w_rd;
            m_wr_data  = data[w*32 +: 32];
            m_ptr      = (w + 1) % NREQ;
        end else begin
            m_wr_valid = 1'b0;
        end
        granted = w;
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, ".rf_write"}, 64'(rf_write), 64'd0);
        checkOutput({tag, ".busy_mask"}, 64'(busy_mask), 64'd0);
        checkOutput({tag, ".hazard_rs1"}, 64'(hazard_rs1), 64'd0);
        checkOutput({tag, ".hazard_rs2"}, 64'(hazard_rs2), 64'd0);
    endtask

    initial begin
        int          g;
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] data;

        compared   = 0;
        mismatched = 0;
        modelReset();
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i]    = 1'b0;
            pend_rd[i]   = '0;
            pend_data[i] = '0;
        end

        // Reset held with all requests valid: nothing granted.
        reset         = 1'b1;
        req_valid     = 3'b111;
        req_rd        = {5'd7, 5'd6, 5'd5};
        req_data      = {32'hC, 32'hB, 32'hA};
        reserve_valid = 1'b0;
        reserve_rd    = '0;
        flush         = 1'b0;
        rs1           = 5'd5;
        rs2           = 5'd6;
        repeat (2) @(negedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;

        $display("[TB] round-robin sequence");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA},
                          1'b0, 5'd0, 1'b0, 5'd5, 5'd7, g);
            checkOutput("rr_winner", 64'(g), 64'(i % NREQ));
        end
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, g);

        $display("[TB] scoreboard sequence");
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, g);
        checkOutput("busy9_set", 64'(busy_mask[9]), 64'd1);
        applyStimulus(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h1234, 32'h0},
                      1'b0, 5'd0, 1'b0, 5'd9, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, g);

        $display("[TB] simultaneous set and clear");
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0, g);
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'h55},
                      1'b0, 5'd0, 1'b0, 5'd12, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd0, g);
        checkOutput("busy12_kept", 64'(busy_mask[12]), 64'd1);

        $display("[TB] x0 sequence");
        applyStimulus(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFF_FFFF, 64'h0},
                      1'b1, 5'd0, 1'b0, 5'd0, 5'd0, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, g);

        $display("[TB] flush with write in flight");
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4, g);
        applyStimulus(3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'h3333, 32'h0},
                      1'b1, 5'd4, 1'b0, 5'd3, 5'd4, g);
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd7, 1'b1, 5'd3, 5'd4, g);
        applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, g);

        $display("[TB] reset with write in flight");
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd8, 1'b0, 5'd8, 5'd0, g);
        applyStimulus(3'b100, {5'd8, 5'd0, 5'd0}, {32'h8888, 64'h0},
                      1'b0, 5'd0, 1'b0, 5'd8, 5'd0, g);
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(3'b110, {5'd2, 5'd1, 5'd0}, {32'h2, 32'h1, 32'h0},
                      1'b0, 5'd0, 1'b0, 5'd1, 5'd2, g);
        checkOutput("ptr_after_reset", 64'(g), 64'd1);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[i]    = 1'b1;
                    pend_rd[i]   = 5'($urandom_range(0, 15));
                    pend_data[i] = $urandom;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                v[i]            = pend_v[i];
                rd[i*5 +: 5]    = pend_rd[i];
                data[i*32 +: 32] = pend_data[i];
            end
            if (cyc == 200) begin
                reset = 1'b1;
                #1;
                checkResetState("randreset");
                modelReset();
                @(negedge clk);
                reset = 1'b0;
            end
            applyStimulus(v, rd, data, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 15)),
                          ($urandom_range(0, 19) == 0),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                          g);
            if (g >= 0) pend_v[g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (x0 reads as zero).
- Arbitrates writeback requests from NREQ producers (ALU, load unit, CSR unit) using round-robin, one write per cycle.
- Keeps a pending-write scoreboard: one busy bit per register, set at issue and cleared at writeback.
- The issue stage uses the hazard outputs to stall.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register index width (2**AW registers)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester writeback request
req_rd  in  NREQ*AW  destination index; requester i at bits [i*AW +: AW]
req_data  in  NREQ*XLEN  write data; requester i at bits [i*XLEN +: XLEN]
req_ready  out  NREQ  one-hot grant; the request is consumed this cycle
rf_write  out  1  register file write enable
rf_rd  out  AW  register file destination index
rf_writedata  out  XLEN  register file write data
reserve_valid  in  1  issue stage reserves a destination
reserve_rd  in  AW  register being reserved
flush  in  1  synchronous clear of all busy bits
rs1  in  AW  issue-stage source 1 index
rs2  in  AW  issue-stage source 2 index
hazard_rs1  out  1  rs1 has a pending write
hazard_rs2  out  1  rs2 has a pending write
busy_mask  out  2**AW  scoreboard state, bit 0 always 0

Behaviour:
- Reset (asynchronous, while reset=1):
  - rf_write=0, rf_rd=0, rf_writedata=0.
  - busy_mask=0, RR pointer=0.
  - req_ready=0 and hazard_rs1/hazard_rs2=0, forced while reset=1.
- Arbitration (combinational within the cycle):
  - Search req_valid starting at index ptr, ascending with wrap at NREQ-1→0.
  - The first valid index wins and only its req_ready bit is 1.
  - No valid request: req_ready=0 and the pointer holds.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - A requester not granted must hold valid, rd and data stable until granted.
  - The arbiter never drops a valid request.
- Pointer update:
  - On a transfer by requester w, ptr <= (w==NREQ-1) ? 0 : w+1.
  - Guarantees a granted requester waits at most NREQ-1 cycles.
- Write port timing:
  - Registered, latency 1. Transfer at edge N: rf_write=1 with rf_rd/rf_writedata from the winner during cycle N+1.
  - The register file captures the write at edge N+1.
  - No transfer at edge N: rf_write=0 in cycle N+1; rf_rd and rf_writedata hold their last values.
- rd=0 requests:
  - Granted and consumed normally.
  - rf_write stays 0 for that slot; busy bit 0 untouched.
- Scoreboard:
  - Reserve: reserve_valid & reserve_rd!=0 at an edge sets busy[reserve_rd].
  - Clear: busy[rd] clears at the edge where the registered write issues, i.e. the edge ending the cycle in which rf_write=1.
  - Same-edge set and clear on the same rd: set wins (newer reservation outstanding).
  - Set/clear on different rds both apply.
  - flush=1 clears every busy bit at the edge. Reservations in the same cycle are discarded; in-flight writes still complete.
  - reserve_rd=0 is ignored; busy_mask[0] is constant 0.
- Hazards (combinational):
  - hazard_rsX = busy[rsX] | (rf_write & rf_rd==rsX & rsX!=0).
  - The second term covers the write-in-progress cycle, because the register file read is not write-through.
- Reset mid-operation: the pending registered write is discarded (rf_write=0), the scoreboard clears, and ptr returns to 0.
- One write per cycle maximum. The block never stalls the register file and has no internal FIFO.

Test Plan:
- Reset: assert reset with req_valid=3'b111 -> req_ready=0, rf_write=0, busy_mask=0. Deassert -> req_ready=3'b001 in the same cycle.
- Round-robin: hold req_valid=3'b111, rd=5/6/7, data=0xA/0xB/0xC -> grants 001,010,100,001 on consecutive edges. rf_write each following cycle with (5,0xA),(6,0xB),(7,0xC),(5,0xA).
- Scoreboard: reserve x9 at edge 0 -> busy_mask[9]=1, hazard_rs1=1 for rs1=9. Requester 1 writes rd=9, data=0x1234 at edge 3 -> rf_write=1, rd=9 in cycle 4; hazard_rs1 still 1 in cycle 4; busy[9]=0 and hazard 0 from cycle 5.
- Simultaneous set/clear: in the cycle rf_write=1 with rd=12, reserve_valid=1, reserve_rd=12 -> busy[12] remains 1 after the edge.
- x0: reserve_rd=0 and request rd=0 data=0xFFFF_FFFF -> req_ready=1, rf_write=0, busy_mask=0, hazard_rs1=0 for rs1=0.
- Flush/reset mid-op: busy=x3,x4, grant pending -> flush: busy_mask=0 next cycle and the write still issues. Repeat with reset -> rf_write=0 immediately, ptr=0.
